// File: rtl/cyq_ssd_capture.sv
// Loopback monitor for the 4-digit multiplexed seven-segment scan driver.
// Synchronizes COM/segment lines, qualifies stable scan slots and decodes them back to hex.
module cyq_ssd_capture #(
  parameter int unsigned STABLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 4
) (
  input  logic       Clk,
  input  logic       Aclr,
  input  logic       COM_1,
  input  logic       COM_2,
  input  logic       COM_3,
  input  logic       COM_4,
  input  logic       a,
  input  logic       b,
  input  logic       c,
  input  logic       d,
  input  logic       e,
  input  logic       f,
  input  logic       g,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3,
  output logic [3:0] digit_vld,
  output logic       frame_done,
  output logic       seg_err
);

  // Bus layout: {COM_4..COM_1, a..g}; idle is all strobes high, all segments dark.
  localparam logic [10:0]      IDLE_PAT = {4'b1111, 7'b0000000};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);

  typedef enum logic {
    ST_COUNT,
    ST_HOLD
  } state_t;

  logic [10:0]      pins;
  logic [10:0]      s1_q, s1_d;
  logic [10:0]      s2_q, s2_d;
  logic [10:0]      p_q, p_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           state_q, state_d;
  logic [3:0][3:0]  dig_q, dig_d;
  logic [3:0]       vld_q, vld_d;
  logic [3:0]       seen_q, seen_d;
  logic             fd_q, fd_d;
  logic             err_q, err_d;
  logic             qualify;
  logic [3:0]       com_lo;
  logic [4:0]       dec;

  assign pins = {COM_4, COM_3, COM_2, COM_1, a, b, c, d, e, f, g};

  // Returns {valid, value}; seg ordered {a,b,c,d,e,f,g}.
  function automatic logic [4:0] seg_decode(input logic [6:0] s);
    case (s)
      7'h7E:   return {1'b1, 4'h0};
      7'h30:   return {1'b1, 4'h1};
      7'h6D:   return {1'b1, 4'h2};
      7'h79:   return {1'b1, 4'h3};
      7'h33:   return {1'b1, 4'h4};
      7'h5B:   return {1'b1, 4'h5};
      7'h5F:   return {1'b1, 4'h6};
      7'h70:   return {1'b1, 4'h7};
      7'h7F:   return {1'b1, 4'h8};
      7'h7B:   return {1'b1, 4'h9};
      7'h77:   return {1'b1, 4'hA};
      7'h1F:   return {1'b1, 4'hB};
      7'h4E:   return {1'b1, 4'hC};
      7'h3D:   return {1'b1, 4'hD};
      7'h4F:   return {1'b1, 4'hE};
      7'h47:   return {1'b1, 4'hF};
      default: return 5'b0;
    endcase
  endfunction

  always_comb begin
    s1_d    = pins;
    s2_d    = s1_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    state_d = state_q;
    dig_d   = dig_q;
    vld_d   = vld_q;
    qualify = 1'b0;

    // A change always restarts the count, even in HOLD.
    if (s2_q != p_q) begin
      p_d     = s2_q;
      cnt_d   = '0;
      state_d = ST_COUNT;
    end else if (state_q == ST_COUNT) begin
      if (cnt_q == CNT_MAX) begin
        qualify = 1'b1;
        state_d = ST_HOLD;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    com_lo = ~p_q[10:7];
    dec    = seg_decode(p_q[6:0]);

    // frame_done is the cycle after seen fills; seen clears on that same edge.
    fd_d   = (seen_q == 4'b1111);
    seen_d = fd_d ? '0 : seen_q;
    err_d  = 1'b0;

    if (qualify && (com_lo != '0)) begin
      if ((com_lo & (com_lo - 4'd1)) != '0) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < 4; i++) begin
          if (com_lo[i]) begin
            seen_d[i] = 1'b1;
            if (dec[4]) begin
              dig_d[i] = dec[3:0];
              vld_d[i] = 1'b1;
            end else begin
              vld_d[i] = 1'b0;
              err_d    = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge Clk or posedge Aclr) begin
    if (Aclr) begin
      s1_q    <= IDLE_PAT;
      s2_q    <= IDLE_PAT;
      p_q     <= IDLE_PAT;
      cnt_q   <= '0;
      state_q <= ST_COUNT;
      dig_q   <= '0;
      vld_q   <= '0;
      seen_q  <= '0;
      fd_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
      dig_q   <= dig_d;
      vld_q   <= vld_d;
      seen_q  <= seen_d;
      fd_q    <= fd_d;
      err_q   <= err_d;
    end
  end

  assign digit0     = dig_q[0];
  assign digit1     = dig_q[1];
  assign digit2     = dig_q[2];
  assign digit3     = dig_q[3];
  assign digit_vld  = vld_q;
  assign frame_done = fd_q;
  assign seg_err    = err_q;

endmodule

// File: tb/tb_cyq_ssd_capture.sv
// Self-checking bench for cyq_ssd_capture: directed scenarios plus randomized scan slots
// compared every cycle against a run-length based behavioural model.
module tb_cyq_ssd_capture;
  localparam int unsigned SC = 4;

  logic       Clk  = 1'b0;
  logic       Aclr = 1'b1;
  logic [3:0] com  = 4'hF;
  logic [6:0] seg  = 7'h00;
  logic [3:0] digit0, digit1, digit2, digit3, digit_vld;
  logic       frame_done, seg_err;

  always #5 Clk = ~Clk;

  cyq_ssd_capture #(.STABLE_CYCLES(SC), .CNT_W(4)) dut (
    .Clk(Clk), .Aclr(Aclr),
    .COM_1(com[0]), .COM_2(com[1]), .COM_3(com[2]), .COM_4(com[3]),
    .a(seg[6]), .b(seg[5]), .c(seg[4]), .d(seg[3]), .e(seg[2]), .f(seg[1]), .g(seg[0]),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3),
    .digit_vld(digit_vld), .frame_done(frame_done), .seg_err(seg_err)
  );

  logic [6:0] tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                           7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

  // Model: the pin stream seen two clocks late; a slot qualifies when its run reaches SC+1 samples.
  logic [10:0] m_s1, m_s2, run_val, v;
  int          run_len;
  logic [3:0]  m_dig [4];
  logic [3:0]  m_vld, m_seen, lowmask;
  logic        m_fd, m_err, nfd;
  int          found, idx;

  always @(posedge Clk or posedge Aclr) begin
    if (Aclr) begin
      m_s1 = 11'h780; m_s2 = 11'h780; run_val = 11'h780; run_len = 1;
      for (int k = 0; k < 4; k++) m_dig[k] = 4'h0;
      m_vld = 4'h0; m_seen = 4'h0; m_fd = 1'b0; m_err = 1'b0;
    end else begin
      v = m_s2; m_s2 = m_s1; m_s1 = {com, seg};
      if (v != run_val) begin
        run_val = v; run_len = 1;
      end else if (run_len < 1000) begin
        run_len = run_len + 1;
      end
      nfd = (m_seen == 4'hF);
      if (nfd) m_seen = 4'h0;
      m_err = 1'b0;
      if (run_len == SC + 1) begin
        lowmask = ~v[10:7];
        if ($countones(lowmask) > 1) begin
          m_err = 1'b1;
        end else if ($countones(lowmask) == 1) begin
          idx = 0;
          for (int k = 0; k < 4; k++) if (lowmask[k]) idx = k;
          found = -1;
          for (int k = 0; k < 16; k++) if (tbl[k] == v[6:0]) found = k;
          m_seen[idx] = 1'b1;
          if (found >= 0) begin
            m_dig[idx] = 4'(found);
            m_vld[idx] = 1'b1;
          end else begin
            m_vld[idx] = 1'b0;
            m_err = 1'b1;
          end
        end
      end
      m_fd = nfd;
    end
  end

  int cmp_checks = 0, cmp_errs = 0, fd_cnt = 0, err_cnt = 0;

  always @(negedge Clk) begin
    logic [3:0] dv [4];
    dv[0] = digit0; dv[1] = digit1; dv[2] = digit2; dv[3] = digit3;
    for (int k = 0; k < 4; k++) begin
      cmp_checks++;
      if (dv[k] !== m_dig[k]) begin
        cmp_errs++;
        $display("FAIL cmp_digit%0d t=%0t got %h want %h", k, $time, dv[k], m_dig[k]);
      end
    end
    cmp_checks++;
    if (digit_vld !== m_vld) begin
      cmp_errs++;
      $display("FAIL cmp_vld t=%0t got %b want %b", $time, digit_vld, m_vld);
    end
    cmp_checks++;
    if (frame_done !== m_fd) begin
      cmp_errs++;
      $display("FAIL cmp_frame_done t=%0t got %b want %b", $time, frame_done, m_fd);
    end
    cmp_checks++;
    if (seg_err !== m_err) begin
      cmp_errs++;
      $display("FAIL cmp_seg_err t=%0t got %b want %b", $time, seg_err, m_err);
    end
    if (frame_done === 1'b1) fd_cnt++;
    if (seg_err === 1'b1) err_cnt++;
  end

  int checks = 0, errors = 0;

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [6:0] s);
    com = c; seg = s;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  int fd0, e0;
  logic [3:0] rc;

  initial begin
    // Reset with a valid digit0 pattern already on the pins.
    Aclr = 1'b1;
    drive(4'b1110, 7'h7E);
    cyc(3);
    lit("reset_digits", {digit3, digit2, digit1, digit0}, 0);
    lit("reset_vld", digit_vld, 0);
    lit("reset_fd_err", {frame_done, seg_err}, 0);
    Aclr = 1'b0;
    cyc(6);
    lit("rel_vld_edge6", digit_vld, 0);
    cyc(1);
    lit("rel_vld_edge7", digit_vld, 4'b0001);
    lit("rel_digit0", digit0, 0);

    // Full frame.
    fd0 = fd_cnt;
    drive(4'b1110, 7'h6D); cyc(10);
    drive(4'b1101, 7'h79); cyc(10);
    drive(4'b1011, 7'h33); cyc(10);
    drive(4'b0111, 7'h5B); cyc(10);
    lit("frame_digits", {digit3, digit2, digit1, digit0}, 16'h5432);
    lit("frame_vld", digit_vld, 4'hF);
    lit("frame_pulses", fd_cnt - fd0, 1);
    lit("model_frame_d3", m_dig[3], 5);

    // Short 0x7F glitch inside a digit1 slot.
    e0 = err_cnt;
    drive(4'b1101, 7'h30); cyc(10);
    drive(4'b1101, 7'h7F); cyc(3);
    drive(4'b1101, 7'h30); cyc(10);
    lit("glitch_digit1", digit1, 1);
    lit("glitch_no_err", err_cnt - e0, 0);

    // Undecodable pattern, then multiple strobes.
    drive(4'b1101, 7'h01); cyc(10);
    lit("bad_seg_err", err_cnt - e0, 1);
    lit("bad_seg_vld1", digit_vld[1], 0);
    lit("bad_seg_digit1", digit1, 1);
    drive(4'b1100, 7'h7E); cyc(10);
    lit("multi_com_err", err_cnt - e0, 2);
    lit("multi_com_digits", {digit3, digit2, digit1, digit0}, 16'h5412);

    // Long hold then blanking.
    fd0 = fd_cnt;
    drive(4'b0111, 7'h47); cyc(100);
    lit("long_digit3", digit3, 4'hF);
    lit("model_long_d3", m_dig[3], 4'hF);
    drive(4'b1111, 7'h00); cyc(50);
    lit("blank_digits", {digit3, digit2, digit1, digit0}, 16'hF412);
    lit("blank_vld", digit_vld, 4'b1101);
    lit("blank_no_frame", fd_cnt - fd0, 0);

    // Reset during the digit2 stable count.
    drive(4'b1011, 7'h4F); cyc(5);
    Aclr = 1'b1; #1;
    lit("midrst_digits", {digit3, digit2, digit1, digit0}, 0);
    lit("midrst_vld", digit_vld, 0);
    cyc(2);
    Aclr = 1'b0;
    cyc(6);
    lit("midrst_vld_edge6", digit_vld, 0);
    cyc(1);
    lit("midrst_digit2", digit2, 4'hE);
    lit("midrst_vld_edge7", digit_vld, 4'b0100);

    // Randomized slots: glitches, blanking, multi-strobe, bad segments, occasional reset.
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) begin
        rc = 4'hF;
        rc[$urandom_range(0, 3)] = 1'b0;
      end else if (r < 8) begin
        rc = 4'hF;
      end else begin
        rc = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 3) == 0) drive(rc, 7'($urandom_range(0, 127)));
      else drive(rc, tbl[$urandom_range(0, 15)]);
      cyc($urandom_range(1, 12));
      if ($urandom_range(0, 49) == 0) begin
        Aclr = 1'b1;
        cyc($urandom_range(1, 3));
        Aclr = 1'b0;
      end
    end

    cyc(5);
    checks = checks + cmp_checks;
    errors = errors + cmp_errs;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
